// File: rtl/apu_frame_sequencer.sv
// rtl/apu_frame_sequencer.sv - APU frame sequencer with delayed $4017 write application
module apu_frame_sequencer #(
    parameter int STEP_PERIOD = 7457,
    parameter int CTR_W       = 13,
    parameter int DELAY_EVEN  = 3,
    parameter int DELAY_ODD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       wr_mode,
    input  logic       wr_irq_inhibit,
    input  logic       clrint,
    output logic       apu_cycle,
    output logic       qtrframe,
    output logic       halfframe,
    output logic       irq,
    output logic [2:0] step,
    output logic       mode,
    output logic       pending
);

    localparam logic [CTR_W-1:0] TICK_AT = CTR_W'(STEP_PERIOD - 1);
    localparam logic [2:0]       D_EVEN  = 3'(DELAY_EVEN);
    localparam logic [2:0]       D_ODD   = 3'(DELAY_ODD);

    logic [CTR_W-1:0] ctr;
    logic [2:0]       dly;
    logic             inhibit;
    logic             pending_mode;
    logic             tick;
    logic             apply;
    logic             irq_set;
    logic             last_step;

    // A write landing on the final delay cycle restarts the delay instead of applying.
    always_comb begin
        tick      = (ctr == TICK_AT);
        apply     = pending && (dly == 3'd1) && !wr;
        last_step = mode ? (step == 3'd4) : (step == 3'd3);
        qtrframe  = 1'b0;
        halfframe = 1'b0;
        irq_set   = 1'b0;
        if (rst) begin
            qtrframe  = 1'b0;
            halfframe = 1'b0;
        end else if (apply) begin
            qtrframe  = pending_mode;
            halfframe = pending_mode;
        end else if (tick) begin
            if (mode) begin
                qtrframe  = (step != 3'd3);
                halfframe = (step == 3'd1) || (step == 3'd4);
            end else begin
                qtrframe  = 1'b1;
                halfframe = (step == 3'd1) || (step == 3'd3);
                irq_set   = (step == 3'd3) && !inhibit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr          <= '0;
            step         <= 3'd0;
            apu_cycle    <= 1'b0;
            mode         <= 1'b0;
            inhibit      <= 1'b0;
            irq          <= 1'b0;
            pending      <= 1'b0;
            pending_mode <= 1'b0;
            dly          <= 3'd0;
        end else begin
            apu_cycle <= ~apu_cycle;

            if (apply) begin
                ctr     <= '0;
                step    <= 3'd0;
                mode    <= pending_mode;
                pending <= 1'b0;
            end else if (tick) begin
                ctr  <= '0;
                step <= last_step ? 3'd0 : step + 3'd1;
            end else begin
                ctr <= ctr + 1'b1;
            end

            if (wr) begin
                inhibit      <= wr_irq_inhibit;
                pending_mode <= wr_mode;
                pending      <= 1'b1;
                dly          <= apu_cycle ? D_ODD : D_EVEN;
            end else if (dly != 3'd0) begin
                dly <= dly - 3'd1;
            end

            // Inhibit write beats a same-cycle set; a set beats a same-cycle $4015 clear.
            if (wr && wr_irq_inhibit)
                irq <= 1'b0;
            else if (irq_set)
                irq <= 1'b1;
            else if (clrint)
                irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb/tb_apu_frame_sequencer.sv - directed bench for apu_frame_sequencer
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       wr_mode = 1'b0;
    logic       wr_irq_inhibit = 1'b0;
    logic       clrint = 1'b0;
    logic       apu_cycle, qtrframe, halfframe, irq, mode, pending;
    logic [2:0] step;

    int cyc = 0;
    int passed = 0;
    int total = 0;

    apu_frame_sequencer #(
        .STEP_PERIOD(8),
        .CTR_W(3),
        .DELAY_EVEN(3),
        .DELAY_ODD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .wr_mode(wr_mode),
        .wr_irq_inhibit(wr_irq_inhibit),
        .clrint(clrint),
        .apu_cycle(apu_cycle),
        .qtrframe(qtrframe),
        .halfframe(halfframe),
        .irq(irq),
        .step(step),
        .mode(mode),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Cycle k is the interval after the k-th edge following reset release.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr = 1'b0;
        clrint = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic do_write(input logic m, input logic inh);
        wr = 1'b1;
        wr_mode = m;
        wr_irq_inhibit = inh;
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_qtr", 8'(qtrframe), 8'd0);
        chk("rst_half", 8'(halfframe), 8'd0);
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("rst_step", 8'(step), 8'd0);
        chk("rst_mode", 8'(mode), 8'd0);
        chk("rst_irq", 8'(irq), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        chk("rst_apu", 8'(apu_cycle), 8'd0);

        // mode 0 sequence
        run_to(7);  chk("m0_t7_qtr", 8'(qtrframe), 8'd1); chk("m0_t7_half", 8'(halfframe), 8'd0);
        run_to(8);  chk("m0_c8_qtr", 8'(qtrframe), 8'd0); chk("m0_c8_step", 8'(step), 8'd1);
        run_to(15); chk("m0_t15_qtr", 8'(qtrframe), 8'd1); chk("m0_t15_half", 8'(halfframe), 8'd1);
        run_to(23); chk("m0_t23_half", 8'(halfframe), 8'd0); chk("m0_t23_step", 8'(step), 8'd2);
        run_to(31); chk("m0_t31_half", 8'(halfframe), 8'd1); chk("m0_t31_irq", 8'(irq), 8'd0);
        run_to(32); chk("m0_c32_irq", 8'(irq), 8'd1); chk("m0_c32_step", 8'(step), 8'd0);
        run_to(40); clrint = 1'b1; #1; chk("clr_c40_irq", 8'(irq), 8'd1);
        run_to(41); chk("clr_c41_irq", 8'(irq), 8'd0);

        // mode 1 write on even parity: apply at 45
        run_to(42); chk("m1_parity", 8'(apu_cycle), 8'd0);
        do_write(1'b1, 1'b0);
        run_to(43); chk("m1_pend43", 8'(pending), 8'd1); chk("m1_qtr43", 8'(qtrframe), 8'd0);
        run_to(45); chk("m1_pend45", 8'(pending), 8'd1); chk("m1_ap_qtr", 8'(qtrframe), 8'd1);
        chk("m1_ap_half", 8'(halfframe), 8'd1); chk("m1_ap_mode", 8'(mode), 8'd0);
        run_to(46); chk("m1_pend46", 8'(pending), 8'd0); chk("m1_step46", 8'(step), 8'd0);
        chk("m1_mode46", 8'(mode), 8'd1);
        run_to(53); chk("m1_s0_qtr", 8'(qtrframe), 8'd1); chk("m1_s0_half", 8'(halfframe), 8'd0);
        run_to(61); chk("m1_s1_qtr", 8'(qtrframe), 8'd1); chk("m1_s1_half", 8'(halfframe), 8'd1);
        run_to(69); chk("m1_s2_qtr", 8'(qtrframe), 8'd1); chk("m1_s2_half", 8'(halfframe), 8'd0);
        run_to(77); chk("m1_s3_qtr", 8'(qtrframe), 8'd0); chk("m1_s3_step", 8'(step), 8'd3);
        run_to(78); chk("m1_s3_irq", 8'(irq), 8'd0);
        run_to(85); chk("m1_s4_qtr", 8'(qtrframe), 8'd1); chk("m1_s4_half", 8'(halfframe), 8'd1);
        run_to(86); chk("m1_wrap_step", 8'(step), 8'd0); chk("m1_wrap_irq", 8'(irq), 8'd0);

        // odd-parity write: apply 4 cycles later at 99
        run_to(95); chk("par_odd", 8'(apu_cycle), 8'd1); chk("par_step95", 8'(step), 8'd1);
        do_write(1'b1, 1'b0);
        run_to(98); chk("par_pend98", 8'(pending), 8'd1); chk("par_qtr98", 8'(qtrframe), 8'd0);
        run_to(99); chk("par_ap_qtr", 8'(qtrframe), 8'd1); chk("par_ap_half", 8'(halfframe), 8'd1);
        run_to(100); chk("par_pend100", 8'(pending), 8'd0); chk("par_step100", 8'(step), 8'd0);

        // restart: write at 100 (mode 1), rewrite at 102 (mode 0) -> single apply at 105
        do_write(1'b1, 1'b0);
        run_to(102); do_write(1'b0, 1'b0);
        run_to(103); chk("rs_pend103", 8'(pending), 8'd1); chk("rs_qtr103", 8'(qtrframe), 8'd0);
        run_to(105); chk("rs_pend105", 8'(pending), 8'd1); chk("rs_qtr105", 8'(qtrframe), 8'd0);
        run_to(106); chk("rs_pend106", 8'(pending), 8'd0); chk("rs_mode106", 8'(mode), 8'd0);

        // inhibit
        run_to(138); chk("inh_irq138", 8'(irq), 8'd1);
        run_to(140); do_write(1'b0, 1'b1);
        run_to(141); chk("inh_irq141", 8'(irq), 8'd0);
        run_to(175); chk("inh_t175_step", 8'(step), 8'd3); chk("inh_t175_qtr", 8'(qtrframe), 8'd1);
        run_to(176); chk("inh_irq176", 8'(irq), 8'd0);
        do_write(1'b0, 1'b0);
        run_to(211); chk("reen_step", 8'(step), 8'd3);
        clrint = 1'b1; #1;
        run_to(212); chk("set_beats_clr", 8'(irq), 8'd1);
        run_to(213); clrint = 1'b1; #1;
        run_to(214); chk("clr214", 8'(irq), 8'd0);

        // apply collides with step-3 tick
        run_to(240); do_write(1'b0, 1'b0);
        run_to(243); chk("col_step243", 8'(step), 8'd3); chk("col_qtr243", 8'(qtrframe), 8'd0);
        chk("col_half243", 8'(halfframe), 8'd0);
        run_to(244); chk("col_irq244", 8'(irq), 8'd0); chk("col_step244", 8'(step), 8'd0);

        // inhibit write coincident with irq set: clear wins
        run_to(275); chk("ic_step275", 8'(step), 8'd3);
        do_write(1'b0, 1'b1);
        run_to(276); chk("ic_irq276", 8'(irq), 8'd0);

        // reset mid-delay cancels pending write; simultaneous write discarded
        run_to(280); do_write(1'b1, 1'b0);
        run_to(282); chk("rp_pend282", 8'(pending), 8'd1);
        rst = 1'b1;
        do_write(1'b1, 1'b0);
        chk("rp_rst_qtr", 8'(qtrframe), 8'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rp_pend", 8'(pending), 8'd0);
        chk("rp_mode", 8'(mode), 8'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rp_no_strobe", 8'(qtrframe), 8'd0);
            next_cycle();
            chk("rp_no_pend", 8'(pending), 8'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
Parametrised APU frame sequencer, next generation of the frame counter. It produces quarter-frame and half-frame strobes, the frame IRQ and the APU half-rate cycle enable. It adds NES-accurate delayed $4017 write application, parity-dependent write latency, an IRQ-inhibit register, and step/mode status outputs. It sits between the CPU register decode ($4017 write, $4015 read-clear) and the envelope, length and sweep units. clk is the CPU-cycle clock.

Parameters:
STEP_PERIOD, 7457, CPU cycles per sequencer step; a tick fires when the counter equals STEP_PERIOD-1.
CTR_W, 13, cycle counter width; must satisfy 2^CTR_W > STEP_PERIOD-1.
DELAY_EVEN, 3, write-to-apply latency in cycles when apu_cycle=0 during the write cycle; must be ≥1.
DELAY_ODD, 4, write-to-apply latency in cycles when apu_cycle=1 during the write cycle; must be ≥1.

Ports:
clk  in  1  CPU-cycle clock
rst  in  1  synchronous active-high reset
wr  in  1  $4017 write strobe, one cycle
wr_mode  in  1  written bit 7 (0 = 4-step, 1 = 5-step)
wr_irq_inhibit  in  1  written bit 6
clrint  in  1  $4015 read, clears frame IRQ
apu_cycle  out  1  toggles every clk
qtrframe  out  1  quarter-frame strobe (combinational, one cycle)
halfframe  out  1  half-frame strobe (combinational, one cycle)
irq  out  1  frame IRQ flag (registered)
step  out  3  current step index
mode  out  1  active mode
pending  out  1  write accepted, not yet applied

Behaviour:
- Reset: counter=0, step=0, apu_cycle=0, mode=0, inhibit=0, irq=0, pending=0, delay counter=0. qtrframe and halfframe are 0 while rst is high.
- Counter: increments every cycle. When counter == STEP_PERIOD-1, that cycle is a tick: the counter becomes 0 next cycle and step advances. Step wraps 3→0 in mode 0 and 4→0 in mode 1.
- Tick strobes in mode 0: qtrframe=1 on every step; halfframe=1 on steps 1 and 3; irq is set on step 3 if inhibit=0.
- Tick strobes in mode 1: qtrframe=1 on steps 0, 1, 2 and 4; halfframe=1 on steps 1 and 4; irq is never set.
- Write handling:
  - On wr, inhibit takes wr_irq_inhibit the next cycle. If wr_irq_inhibit=1, irq is 0 from the next cycle.
  - The written mode is latched as pending_mode and pending=1.
  - The delay counter loads DELAY_ODD if apu_cycle=1 in the write cycle, otherwise DELAY_EVEN.
- Apply: for a write in cycle T with latency D, cycle T+D is the apply cycle.
  - In the apply cycle: counter←0, step←0, mode←pending_mode, pending←0.
  - If pending_mode=1, qtrframe=1 and halfframe=1 in the apply cycle.
  - Until the apply cycle, the sequencer keeps running in the old mode.
- Write while pending: restarts the delay, and the new mode and inhibit values replace the old ones. Last write wins; only one apply occurs.
- Apply coincident with a tick: apply wins. Tick strobes and irq-set from that tick are suppressed. Only the apply-cycle mode-1 strobes appear.
- IRQ priority:
  - set and clrint in the same cycle: set wins (irq=1).
  - Inhibit write with wr_irq_inhibit=1 and set in the same cycle: clear wins.
  - A mode change alone does not clear irq.
  - A write with wr_irq_inhibit=0 leaves irq unchanged.
- wr and rst in the same cycle: rst wins and the write is discarded. Reset mid-delay cancels the pending write.
- Widths: counter is CTR_W bits and never exceeds STEP_PERIOD-1. Delay counter is 3 bits.

Test Plan:
- Mode 0 sequence (STEP_PERIOD=8, rst released at cycle 0): ticks at cycles 7, 15, 23, 31. qtrframe=1 on all four; halfframe=1 at cycles 15 and 31. irq=1 from cycle 32; clrint at cycle 40 → irq=0 at cycle 41.
- Mode 1 write: wr_mode=1 at a cycle with apu_cycle=0 → pending=1 for 3 cycles. In the apply cycle qtrframe=halfframe=1; next cycle step=0, counter=0, mode=1. Over 5 ticks qtrframe is 1 on steps 0, 1, 2, 4 and halfframe is 1 on steps 1, 4; irq stays 0 throughout.
- Write parity: wr with apu_cycle=1 → apply occurs 4 cycles after the write. A second wr before apply restarts the delay, and only the second write's mode takes effect.
- Inhibit: with irq=1, wr_irq_inhibit=1 → irq=0 next cycle, and no irq on subsequent step-3 ticks. A write with wr_irq_inhibit=0 re-enables the IRQ.
- Collision: apply lands on a tick cycle in mode 0 at step 3 → no irq set, step=0 afterwards. clrint coincident with irq-set → irq=1.
- Reset during pending write: rst at delay=2 → pending=0, mode=0, and no apply strobes appear afterwards.
